// File: rtl/alu_seq_if.sv
// Operand/result bundle for the multi-cycle ALU.
// master drives the operation, slave returns the registered result.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      ins;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             r;
   logic             i;
   logic             j;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] hi;
   logic             out_valid;
   logic             branch;
   logic             err;

   modport master (
      output in_valid, ins, a, b, r, i, j,
      input  in_ready, out, hi, out_valid, branch, err
   );

   modport slave (
      input  in_valid, ins, a, b, r, i, j,
      output in_ready, out, hi, out_valid, branch, err
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle R/I/J ops plus iterative
// unsigned multiply (shift-add) and divide (restoring).
module alu_seq #(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     rst_n,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_MULU = 6'b011001;
   localparam logic [5:0] F_DIVU = 6'b011011;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] O_BEQ  = 6'b000100;
   localparam logic [5:0] O_BNE  = 6'b000101;
   localparam logic [5:0] O_ADDI = 6'b001000;
   localparam logic [5:0] O_ANDI = 6'b001100;
   localparam logic [5:0] O_ORI  = 6'b001101;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opd;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] hi_q;
   logic             vld_q;
   logic             br_q;
   logic             err_q;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic [25:0] target;

   assign opcode = bus.ins[31:26];
   assign funct  = bus.ins[5:0];
   assign shamt  = bus.ins[10:6];
   assign imm    = bus.ins[15:0];
   assign target = bus.ins[25:0];

   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_hi;
   logic             res_br;
   logic             res_err;
   logic             res_hi_we;
   logic             go_mul;
   logic             go_div;

   always_comb begin
      res       = '0;
      res_hi    = '0;
      res_br    = 1'b0;
      res_err   = 1'b0;
      res_hi_we = 1'b0;
      go_mul    = 1'b0;
      go_div    = 1'b0;
      priority case (1'b1)
         bus.r: begin
            case (funct)
               F_ADD: res = bus.a + bus.b;
               F_SUB: res = bus.a - bus.b;
               F_AND: res = bus.a & bus.b;
               F_OR:  res = bus.a | bus.b;
               F_SLT: res = {{(WIDTH-1){1'b0}},
                             $signed(bus.a) < $signed(bus.b)};
               F_SLL: res = (int'(shamt) >= WIDTH) ? '0
                            : bus.b << shamt;
               F_SRL: res = (int'(shamt) >= WIDTH) ? '0
                            : bus.b >> shamt;
               F_MULU: go_mul = 1'b1;
               F_DIVU: begin
                  // Divide by zero short-circuits to a one-cycle result
                  if (bus.b == '0) begin
                     res       = '1;
                     res_hi    = bus.a;
                     res_hi_we = 1'b1;
                  end else begin
                     go_div = 1'b1;
                  end
               end
               default: res_err = 1'b1;
            endcase
         end
         bus.i: begin
            case (opcode)
               O_ADDI: res = bus.a + WIDTH'($signed(imm));
               O_ANDI: res = bus.a & WIDTH'(imm);
               O_ORI:  res = bus.a | WIDTH'(imm);
               O_BEQ: begin
                  res    = bus.a - bus.b;
                  res_br = bus.a == bus.b;
               end
               O_BNE: begin
                  res    = bus.a - bus.b;
                  res_br = bus.a != bus.b;
               end
               default: res_err = 1'b1;
            endcase
         end
         bus.j: begin
            res    = WIDTH'({target, 2'b00});
            res_br = 1'b1;
         end
         default: res_err = 1'b1;
      endcase
   end

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] div_hi;
   logic [WIDTH-1:0] div_lo;

   always_comb begin
      mul_sum  = {1'b0, acc_hi}
               + (acc_lo[0] ? {1'b0, opd} : '0);
      mul_hi   = mul_sum[WIDTH:1];
      mul_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
      div_sh   = {acc_hi, acc_lo[WIDTH-1]};
      div_diff = div_sh - {1'b0, opd};
      div_hi   = div_diff[WIDTH] ? div_sh[WIDTH-1:0]
                                 : div_diff[WIDTH-1:0];
      div_lo   = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opd    <= '0;
         out_q  <= '0;
         hi_q   <= '0;
         vld_q  <= 1'b0;
         br_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  cnt <= CW'(WIDTH-1);
                  if (go_mul) begin
                     acc_hi <= '0;
                     acc_lo <= bus.b;
                     opd    <= bus.a;
                     state  <= MUL;
                  end else if (go_div) begin
                     acc_hi <= '0;
                     acc_lo <= bus.a;
                     opd    <= bus.b;
                     state  <= DIV;
                  end else begin
                     out_q <= res;
                     br_q  <= res_br;
                     err_q <= res_err;
                     vld_q <= 1'b1;
                     if (res_hi_we) hi_q <= res_hi;
                  end
               end
            end
            MUL: begin
               acc_hi <= mul_hi;
               acc_lo <= mul_lo;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  out_q <= mul_lo;
                  hi_q  <= mul_hi;
                  br_q  <= 1'b0;
                  err_q <= 1'b0;
                  vld_q <= 1'b1;
                  state <= IDLE;
               end
            end
            DIV: begin
               acc_hi <= div_hi;
               acc_lo <= div_lo;
               cnt    <= cnt - 1'b1;
               if (cnt == '0) begin
                  out_q <= div_lo;
                  hi_q  <= div_hi;
                  br_q  <= 1'b0;
                  err_q <= 1'b0;
                  vld_q <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = state == IDLE;
   assign bus.out       = out_q;
   assign bus.hi        = hi_q;
   assign bus.out_valid = vld_q;
   assign bus.branch    = br_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=16.
// Expected results come from a plain-arithmetic model.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(32)) bus32 ();
   alu_seq_if #(.WIDTH(16)) bus16 ();

   alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
   );
   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16.slave)
   );

   typedef struct {
      logic [63:0] out;
      logic [63:0] hi;
      logic        br;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q32[$];
   exp_t q16[$];
   exp_t e32;
   exp_t e16;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [63:0] mhi32 = '0;
   logic [63:0] mhi16 = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, req);
      end
   endtask

   function automatic exp_t model(input int w,
                                  input logic [31:0] ins,
                                  input logic [63:0] a_in,
                                  input logic [63:0] b_in,
                                  input logic r, input logic i,
                                  input logic j,
                                  input logic [63:0] hprev);
      exp_t e;
      logic [63:0] m, a, b;
      logic [127:0] p;
      longint sa, sb;
      int sh;
      m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a = a_in & m;
      b = b_in & m;
      sh = int'(ins[10:6]);
      e.out = '0; e.hi = hprev; e.br = 1'b0;
      e.err = 1'b0; e.cyc = 0;
      if (r) begin
         case (ins[5:0])
            6'h20: e.out = a + b;
            6'h22: e.out = a - b;
            6'h24: e.out = a & b;
            6'h25: e.out = a | b;
            6'h2a: begin
               sa = $signed(a << (64 - w)) >>> (64 - w);
               sb = $signed(b << (64 - w)) >>> (64 - w);
               e.out = (sa < sb) ? 64'd1 : 64'd0;
            end
            6'h00: e.out = (sh >= w) ? '0 : (b << sh);
            6'h02: e.out = (sh >= w) ? '0 : (b >> sh);
            6'h19: begin
               p = {64'd0, a} * {64'd0, b};
               e.out = p[63:0];
               e.hi = 64'(p >> w) & m;
               e.cyc = w;
            end
            6'h1b: begin
               if (b == 0) begin
                  e.out = m;
                  e.hi = a;
               end else begin
                  e.out = a / b;
                  e.hi = a % b;
                  e.cyc = w;
               end
            end
            default: e.err = 1'b1;
         endcase
      end else if (i) begin
         case (ins[31:26])
            6'h08: e.out = a + 64'($signed(ins[15:0]));
            6'h0c: e.out = a & {48'd0, ins[15:0]};
            6'h0d: e.out = a | {48'd0, ins[15:0]};
            6'h04: begin e.out = a - b; e.br = (a == b); end
            6'h05: begin e.out = a - b; e.br = (a != b); end
            default: e.err = 1'b1;
         endcase
      end else if (j) begin
         e.out = {36'd0, ins[25:0], 2'b00};
         e.br = 1'b1;
      end else begin
         e.err = 1'b1;
      end
      e.out = e.out & m;
      return e;
   endfunction

   function automatic logic [31:0] rins(input logic [5:0] f,
                                        input logic [4:0] s);
      return {6'd0, 15'd0, s, f};
   endfunction

   function automatic logic [31:0] iins(input logic [5:0] op,
                                        input logic [15:0] im);
      return {op, 10'd0, im};
   endfunction

   task automatic issue(input bit w16, input logic [31:0] ins,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic r, input logic i, input logic j,
                        input bit expect_res, output int waited);
      exp_t e;
      e = model(w16 ? 16 : 32, ins, a, b, r, i, j,
                w16 ? mhi16 : mhi32);
      if (w16) begin
         bus16.ins = ins; bus16.a = a[15:0]; bus16.b = b[15:0];
         bus16.r = r; bus16.i = i; bus16.j = j;
         bus16.in_valid = 1'b1;
      end else begin
         bus32.ins = ins; bus32.a = a[31:0]; bus32.b = b[31:0];
         bus32.r = r; bus32.i = i; bus32.j = j;
         bus32.in_valid = 1'b1;
      end
      waited = 0;
      while (!(w16 ? bus16.in_ready : bus32.in_ready)
             && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 200) begin
         checks++;
         errors++;
         $display("FAIL accept timeout: in_ready=0 expected 1");
      end else if (expect_res) begin
         e.cyc = cyc + 1 + e.cyc;
         if (w16) begin q16.push_back(e); mhi16 = e.hi; end
         else begin q32.push_back(e); mhi32 = e.hi; end
      end
      @(negedge clk);
      bus16.in_valid = 1'b0;
      bus32.in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bus32.out_valid === 1'b1) begin
         if (q32.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w32 spurious pulse: out_valid=1 expected 0");
         end else begin
            e32 = q32.pop_front();
            chk("w32 out", 64'(bus32.out), e32.out);
            chk("w32 hi", 64'(bus32.hi), e32.hi);
            chk("w32 branch", 64'(bus32.branch), 64'(e32.br));
            chk("w32 err", 64'(bus32.err), 64'(e32.err));
            chk("w32 cycle", 64'(cyc), 64'(e32.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (bus16.out_valid === 1'b1) begin
         if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w16 spurious pulse: out_valid=1 expected 0");
         end else begin
            e16 = q16.pop_front();
            chk("w16 out", 64'(bus16.out), e16.out);
            chk("w16 hi", 64'(bus16.hi), e16.hi);
            chk("w16 branch", 64'(bus16.branch), 64'(e16.br));
            chk("w16 err", 64'(bus16.err), 64'(e16.err));
            chk("w16 cycle", 64'(cyc), 64'(e16.cyc));
         end
      end
   end

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'd1;
         2: return '1;
         3: return 64'h8000_8000;
         4: return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int wt;
      logic [5:0] rf [10];
      logic [5:0] iop [6];
      logic [31:0] ins;
      logic r, i, j;
      bit w16;
      rf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a,
             6'h00, 6'h02, 6'h19, 6'h1b, 6'h3f};
      iop = '{6'h08, 6'h0c, 6'h0d, 6'h04, 6'h05, 6'h3e};
      bus32.in_valid = 0; bus32.ins = 0; bus32.a = 0; bus32.b = 0;
      bus32.r = 0; bus32.i = 0; bus32.j = 0;
      bus16.in_valid = 0; bus16.ins = 0; bus16.a = 0; bus16.b = 0;
      bus16.r = 0; bus16.i = 0; bus16.j = 0;
      repeat (3) @(negedge clk);
      chk("reset in_ready", 64'(bus32.in_ready), 64'd1);
      chk("reset out", 64'(bus32.out), 64'd0);
      chk("reset hi", 64'(bus32.hi), 64'd0);
      chk("reset out_valid", 64'(bus32.out_valid), 64'd0);
      chk("reset branch", 64'(bus32.branch), 64'd0);
      chk("reset err", 64'(bus32.err), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset in_ready", 64'(bus32.in_ready), 64'd1);

      issue(0, rins(6'h20, 0), 10, 5, 1, 0, 0, 1, wt);
      issue(0, rins(6'h25, 0), 10, 17, 1, 0, 0, 1, wt);
      chk("back-to-back accept wait", 64'(wt), 64'd0);
      issue(0, iins(6'h08, 16'hfffc), 2, 0, 0, 1, 0, 1, wt);
      issue(0, iins(6'h05, 0), 2, 1, 0, 1, 0, 1, wt);
      issue(0, iins(6'h04, 0), 2, 1, 0, 1, 0, 1, wt);
      issue(0, 32'h0000_0040, 0, 0, 0, 0, 1, 1, wt);
      issue(0, rins(6'h19, 0), 64'hffff_ffff, 2, 1, 0, 0, 1, wt);
      issue(0, rins(6'h1b, 0), 100, 7, 1, 0, 0, 1, wt);
      chk("multu busy cycles", 64'(wt), 64'd32);
      issue(0, rins(6'h1b, 0), 5, 0, 1, 0, 0, 1, wt);
      chk("divu busy cycles", 64'(wt), 64'd32);
      issue(0, rins(6'h3f, 0), 3, 4, 1, 0, 0, 1, wt);
      chk("divu b=0 busy cycles", 64'(wt), 64'd0);
      issue(0, rins(6'h20, 0), 3, 4, 0, 0, 0, 1, wt);
      issue(0, rins(6'h00, 5'd31), 1, 3, 1, 0, 0, 1, wt);

      issue(1, rins(6'h19, 0), 64'hffff, 2, 1, 0, 0, 1, wt);
      issue(1, rins(6'h00, 5'd16), 1, 3, 1, 0, 0, 1, wt);
      chk("w16 multu busy cycles", 64'(wt), 64'd16);
      issue(1, 32'h0000_0040, 0, 0, 0, 0, 1, 1, wt);

      issue(0, rins(6'h19, 0), 123, 456, 1, 0, 0, 0, wt);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      mhi32 = '0;
      mhi16 = '0;
      chk("abort in_ready", 64'(bus32.in_ready), 64'd1);
      chk("abort out", 64'(bus32.out), 64'd0);
      chk("abort hi", 64'(bus32.hi), 64'd0);
      chk("abort out_valid", 64'(bus32.out_valid), 64'd0);
      chk("abort err", 64'(bus32.err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort idle in_ready", 64'(bus32.in_ready), 64'd1);

      for (int n = 0; n < 160; n++) begin
         w16 = ($urandom_range(0, 3) == 0);
         r = 0; i = 0; j = 0;
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: begin
               r = 1;
               ins = rins(rf[$urandom_range(0, 9)],
                          5'($urandom_range(0, 31)));
            end
            5, 6, 7: begin
               i = 1;
               ins = iins(iop[$urandom_range(0, 5)],
                          16'($urandom));
            end
            8: begin
               j = 1;
               ins = $urandom;
            end
            default: ins = $urandom;
         endcase
         if (r == 1 && $urandom_range(0, 1) == 1) begin
            i = 1;
            j = $urandom_range(0, 1) == 1;
         end
         issue(w16, ins, pick(), pick(), r, i, j, 1, wt);
      end

      for (int t = 0; t < 200 && (q32.size() != 0
                                  || q16.size() != 0); t++)
         @(negedge clk);
      chk("w32 pending results", 64'(q32.size()), 64'd0);
      chk("w16 pending results", 64'(q16.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
